pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Parametrised successor to the basic PIC program counter. It generates the Q1..Q4 phase ring and the
//  instruction address for the instruction ROM, with a hardware CALL/RETLW return stack and PCL writes
//  (computed goto). Sits between the instruction decoder (control strobes) and the instruction memory.
// PARAMETERS
//  PC_W          L2_PIC_INSTR_MEM_DEPTH  program counter width in bits
//  STACK_DEPTH   2                       return stack entries; must be >=1
//  CALL_ADDR_W   8                       CALL target width; target zero-extended to PC_W
//  PCL_W         8                       PCL write width; PC bits above PCL_W cleared on PCL write
//  RESET_VECTOR  0                       PC value loaded by reset
// PORTS
//  clk          in   1              system clock
//  rst          in   1              reset, asynchronous, active-high
//  pc           out  PC_W           current instruction address
//  q1,q2,q3,q4  out  1 each         one-hot instruction phase ring
//  goto_enable  in   1              GOTO strobe, sampled in Q4
//  goto_addr    in   PC_W           GOTO target
//  call_enable  in   1              CALL strobe, sampled in Q4
//  call_addr    in   CALL_ADDR_W    CALL target
//  ret_enable   in   1              RETLW/return strobe, sampled in Q4
//  pcl_we       in   1              PCL write strobe, sampled in Q4
//  pcl_data     in   PCL_W          PCL write data
//  skip         in   1              skip next instruction, sampled in Q4
//  stack_level  out  $clog2(STACK_DEPTH+1)  valid entries, saturates at STACK_DEPTH
//  stack_ovf    out  1              sticky overflow flag (see CONFIGURATION)
//  stack_unf    out  1              sticky underflow flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async, immediate): pc=RESET_VECTOR; {q1,q2,q3,q4}=4'b1000; stack ptr=0; stack_level=0;
//    flags=0; stack contents are not reset and are don't-care. Reset mid-cycle aborts any pending update.
//  - Phase ring rotates q1->q2->q3->q4->q1 every clk, with no stall. One instruction takes 4 clks.
//  - PC and stack change only on the clk edge where q4=1. The new pc is visible in the following Q1.
//  - Priority when several strobes are set: ret > call > goto > pcl_we > skip > increment.
//      ret:    pc<=stack[ptr-1]; ptr<=ptr-1 (mod STACK_DEPTH); level<=level-1 unless 0
//      call:   stack[ptr]<=pc+1; ptr<=ptr+1 (mod); level<=min(level+1,STACK_DEPTH); pc<=zext(call_addr)
//      goto:   pc<=goto_addr
//      pcl_we: pc<=zext(pcl_data)
//      skip:   pc<=pc+2
//      else:   pc<=pc+1
//  - All PC arithmetic is modulo 2^PC_W: pc=max, +1 gives 0; pc=max-1, +2 gives 0.
//  - The stack is circular. A push when level==STACK_DEPTH overwrites the oldest entry (overflow).
//    A pop when level==0 still reads stack[ptr-1] and wraps ptr (underflow). This matches PIC semantics.
//  - Strobes outside Q4 are ignored.
// CONFIGURATION
//  PC_SEQ_STACK_STATUS_EN
//   - Defined: stack_ovf is set by a push at level==STACK_DEPTH; stack_unf is set by a pop at level==0.
//     Both are sticky until reset.
//   - Undefined: stack_ovf and stack_unf are tied 0 and no flag logic is built. Ports stay present.
// STRUCTURE
//  - pic_params.v supplies L2_PIC_INSTR_MEM_DEPTH. Add the stack-op localparams (OP_NONE/PUSH/POP)
//    and the strobe priority order there so the decoder and this block share them.
//  - Sub-module pc_return_stack: STACK_DEPTH x PC_W register file, pointer, level counter, push/pop
//    ports, and the optional flags. It carries the same clk/rst convention.
//  - Top-level pc_sequencer holds the phase ring, the PC register and the priority mux.
// TESTING
//  1. Reset with RESET_VECTOR=0x1F8, then no strobes for 12 clks -> pc steps 0x1F8,0x1F9,0x1FA;
//     q ring 1000,0100,0010,0001 repeating.
//  2. pc=0x1FF, increment -> pc=0x000. pc=0x1FE, skip -> pc=0x000.
//  3. pc=0x010, call 0x40 -> pc=0x040, level=1. Then ret -> pc=0x011, level=0.
//  4. STACK_DEPTH=2: calls at 0x010,0x040,0x080 -> level=2 and stack_ovf=1 (EN). Three rets
//     -> 0x081, 0x041, 0x081 (oldest entry lost); stack_unf=1 after the third (EN).
//  5. Assert goto_enable=1, goto_addr=0x055 and call_enable=1 in the same Q4 -> call wins.
//     The same strobes in Q2 only -> pc increments.
//  6. Assert rst mid-Q3 after pc=0x033 -> pc=RESET_VECTOR immediately, q=1000, level=0, flags=0.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PIC program counter sequencer and the instruction decoder:
// memory depth, stack-op codes, phase ring encoding and the strobe priority order.
package pc_sequencer_pkg;

    localparam int L2_PIC_INSTR_MEM_DEPTH = 9;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_PUSH = 2'd1,
        OP_POP  = 2'd2
    } stack_op_t;

    // Enumerated in strobe priority order, highest first.
    typedef enum logic [2:0] {
        SRC_RET  = 3'd0,
        SRC_CALL = 3'd1,
        SRC_GOTO = 3'd2,
        SRC_PCL  = 3'd3,
        SRC_SKIP = 3'd4,
        SRC_INC  = 3'd5
    } pc_src_t;

    typedef enum logic [3:0] {
        PH_Q1 = 4'b1000,
        PH_Q2 = 4'b0100,
        PH_Q3 = 4'b0010,
        PH_Q4 = 4'b0001
    } phase_t;

    function automatic pc_src_t pc_select(input logic ret_en, input logic call_en,
                                          input logic goto_en, input logic pcl_en,
                                          input logic skip_en);
        pc_src_t src;
        if (ret_en)       src = SRC_RET;
        else if (call_en) src = SRC_CALL;
        else if (goto_en) src = SRC_GOTO;
        else if (pcl_en)  src = SRC_PCL;
        else if (skip_en) src = SRC_SKIP;
        else              src = SRC_INC;
        return src;
    endfunction

endpackage

// File: rtl/pc_return_stack.sv
// Circular CALL/RETLW return stack with saturating level counter.
// Optional sticky overflow/underflow flags are built when PC_SEQ_STACK_STATUS_EN is defined.
module pc_return_stack
    import pc_sequencer_pkg::*;
#(
    parameter int PC_W        = L2_PIC_INSTR_MEM_DEPTH,
    parameter int STACK_DEPTH = 2,
    localparam int LVL_W      = $clog2(STACK_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  stack_op_t        op,
    input  logic [PC_W-1:0]  push_data,
    output logic [PC_W-1:0]  top,
    output logic [LVL_W-1:0] level,
    output logic             ovf,
    output logic             unf
);

    localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [LVL_W-1:0] FULL = LVL_W'(STACK_DEPTH);

    logic [PC_W-1:0]  mem [STACK_DEPTH];
    logic [PTR_W-1:0] ptr_reg;
    logic [PTR_W-1:0] ptr_inc;
    logic [PTR_W-1:0] ptr_dec;
    logic [LVL_W-1:0] level_reg;

    always_comb begin
        ptr_inc = (ptr_reg == PTR_W'(STACK_DEPTH - 1)) ? '0 : ptr_reg + 1'b1;
        ptr_dec = (ptr_reg == '0) ? PTR_W'(STACK_DEPTH - 1) : ptr_reg - 1'b1;
    end

    // A pop always reads the slot below the pointer, even when empty (PIC underflow behaviour).
    assign top   = mem[ptr_dec];
    assign level = level_reg;

    // Entries hold no reset: contents are don't-care until written.
    for (genvar gi = 0; gi < STACK_DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (op == OP_PUSH && ptr_reg == PTR_W'(gi)) begin
                mem[gi] <= push_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg   <= '0;
            level_reg <= '0;
        end else begin
            case (op)
                OP_PUSH: begin
                    ptr_reg <= ptr_inc;
                    if (level_reg != FULL) level_reg <= level_reg + 1'b1;
                end
                OP_POP: begin
                    ptr_reg <= ptr_dec;
                    if (level_reg != '0) level_reg <= level_reg - 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef PC_SEQ_STACK_STATUS_EN
    logic ovf_reg;
    logic unf_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_reg <= 1'b0;
            unf_reg <= 1'b0;
        end else begin
            if (op == OP_PUSH && level_reg == FULL) ovf_reg <= 1'b1;
            if (op == OP_POP && level_reg == '0)    unf_reg <= 1'b1;
        end
    end

    assign ovf = ovf_reg;
    assign unf = unf_reg;
`else
    assign ovf = 1'b0;
    assign unf = 1'b0;
`endif

endmodule

// File: rtl/pc_sequencer.sv
// PIC program counter: Q1..Q4 phase ring, PC register and strobe priority mux over a return stack.
// Define PC_SEQ_STACK_STATUS_EN to build the sticky stack_ovf/stack_unf flags.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int              PC_W         = L2_PIC_INSTR_MEM_DEPTH,
    parameter int              STACK_DEPTH  = 2,
    parameter int              CALL_ADDR_W  = 8,
    parameter int              PCL_W        = 8,
    parameter logic [PC_W-1:0] RESET_VECTOR = '0,
    localparam int             LVL_W        = $clog2(STACK_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [PC_W-1:0]        pc,
    output logic                   q1,
    output logic                   q2,
    output logic                   q3,
    output logic                   q4,
    input  logic                   goto_enable,
    input  logic [PC_W-1:0]        goto_addr,
    input  logic                   call_enable,
    input  logic [CALL_ADDR_W-1:0] call_addr,
    input  logic                   ret_enable,
    input  logic                   pcl_we,
    input  logic [PCL_W-1:0]       pcl_data,
    input  logic                   skip,
    output logic [LVL_W-1:0]       stack_level,
    output logic                   stack_ovf,
    output logic                   stack_unf
);

    phase_t          phase_reg;
    logic [PC_W-1:0] pc_reg;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] stack_top;
    pc_src_t         src;
    stack_op_t       op;

    always_comb begin
        src     = pc_select(ret_enable, call_enable, goto_enable, pcl_we, skip);
        pc_next = pc_reg + 1'b1;
        op      = OP_NONE;
        case (src)
            SRC_RET:  begin pc_next = stack_top;             op = OP_POP;  end
            SRC_CALL: begin pc_next = PC_W'(call_addr);      op = OP_PUSH; end
            SRC_GOTO: pc_next = goto_addr;
            SRC_PCL:  pc_next = PC_W'(pcl_data);
            SRC_SKIP: pc_next = pc_reg + PC_W'(2);
            default:  pc_next = pc_reg + 1'b1;
        endcase
        // Stack only moves on the Q4 edge; strobes in other phases are ignored.
        if (phase_reg != PH_Q4) op = OP_NONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_reg <= PH_Q1;
            pc_reg    <= RESET_VECTOR;
        end else begin
            case (phase_reg)
                PH_Q1:   phase_reg <= PH_Q2;
                PH_Q2:   phase_reg <= PH_Q3;
                PH_Q3:   phase_reg <= PH_Q4;
                default: phase_reg <= PH_Q1;
            endcase
            if (phase_reg == PH_Q4) pc_reg <= pc_next;
        end
    end

    pc_return_stack #(
        .PC_W        (PC_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .op        (op),
        .push_data (pc_reg + 1'b1),
        .top       (stack_top),
        .level     (stack_level),
        .ovf       (stack_ovf),
        .unf       (stack_unf)
    );

    assign pc               = pc_reg;
    assign {q1, q2, q3, q4} = phase_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized strobes against a reference model.
module tb_pc_sequencer;

    localparam int          PC_W  = 9;
    localparam int          DEPTH = 2;
    localparam int          MASK  = (1 << PC_W) - 1;
    localparam logic [8:0]  RV    = 9'h1F8;
`ifdef PC_SEQ_STACK_STATUS_EN
    localparam bit FLAGS_EN = 1'b1;
`else
    localparam bit FLAGS_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [8:0] pc;
    logic       q1, q2, q3, q4;
    logic       goto_enable = 1'b0;
    logic [8:0] goto_addr = '0;
    logic       call_enable = 1'b0;
    logic [7:0] call_addr = '0;
    logic       ret_enable = 1'b0;
    logic       pcl_we = 1'b0;
    logic [7:0] pcl_data = '0;
    logic       skip = 1'b0;
    logic [1:0] stack_level;
    logic       stack_ovf, stack_unf;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int m_pc, m_ptr, m_level;
    int m_stack [DEPTH];
    bit m_known [DEPTH];
    bit m_ovf, m_unf;

    pc_sequencer #(
        .PC_W(PC_W), .STACK_DEPTH(DEPTH), .CALL_ADDR_W(8), .PCL_W(8), .RESET_VECTOR(RV)
    ) dut (
        .clk(clk), .rst(rst), .pc(pc), .q1(q1), .q2(q2), .q3(q3), .q4(q4),
        .goto_enable(goto_enable), .goto_addr(goto_addr), .call_enable(call_enable),
        .call_addr(call_addr), .ret_enable(ret_enable), .pcl_we(pcl_we), .pcl_data(pcl_data),
        .skip(skip), .stack_level(stack_level), .stack_ovf(stack_ovf), .stack_unf(stack_unf)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        m_pc = RV; m_ptr = 0; m_level = 0; m_ovf = 0; m_unf = 0;
        for (int i = 0; i < DEPTH; i++) m_known[i] = 0;
    endfunction

    function automatic void model_step(input bit r, input bit c, input bit g, input int ga,
                                       input int ca, input bit w, input int pd, input bit s);
        int idx;
        if (r) begin
            if (m_level == 0) m_unf = 1;
            idx = (m_ptr + DEPTH - 1) % DEPTH;
            m_pc = m_stack[idx];
            m_ptr = idx;
            if (m_level > 0) m_level--;
        end else if (c) begin
            if (m_level == DEPTH) m_ovf = 1;
            m_stack[m_ptr] = (m_pc + 1) & MASK;
            m_known[m_ptr] = 1;
            m_ptr = (m_ptr + 1) % DEPTH;
            if (m_level < DEPTH) m_level++;
            m_pc = ca;
        end else if (g) m_pc = ga;
        else if (w)     m_pc = pd;
        else if (s)     m_pc = (m_pc + 2) & MASK;
        else            m_pc = (m_pc + 1) & MASK;
    endfunction

    task automatic clear_strobes();
        goto_enable = 0; call_enable = 0; ret_enable = 0; pcl_we = 0; skip = 0;
    endtask

    task automatic wait_phase(input logic [3:0] ph);
        int n = 0;
        while ({q1, q2, q3, q4} !== ph && n < 8) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ({q1, q2, q3, q4} !== ph) begin
            errors++;
            $display("FAIL wait_phase: q=%b never reached %b", {q1, q2, q3, q4}, ph);
        end
    endtask

    // Drives one instruction's strobes during Q4 and advances the model; returns in the next Q1.
    task automatic run_instr(input bit r, input bit c, input bit g, input logic [8:0] ga,
                             input logic [7:0] ca, input bit w, input logic [7:0] pd, input bit s);
        wait_phase(4'b0001);
        ret_enable = r; call_enable = c; goto_enable = g; goto_addr = ga;
        call_addr = ca; pcl_we = w; pcl_data = pd; skip = s;
        @(posedge clk);
        #1;
        clear_strobes();
        model_step(r, c, g, int'(ga), int'(ca), w, int'(pd), s);
        $display("instr r=%0b c=%0b g=%0b w=%0b s=%0b -> pc=%03h level=%0d", r, c, g, w, s, pc, stack_level);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        clear_strobes();
        model_reset();
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (pc !== RV) begin errors++; $display("FAIL reset_pc: got %03h want %03h", pc, RV); end
        checks++; if ({q1, q2, q3, q4} !== 4'b1000) begin errors++; $display("FAIL reset_q: got %b want 1000", {q1, q2, q3, q4}); end
        checks++; if (stack_level !== 2'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", stack_level); end
        checks++; if ({stack_ovf, stack_unf} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {stack_ovf, stack_unf}); end
    endtask

    task automatic test_phase_ring();
        logic [3:0] ring [4];
        ring[0] = 4'b1000; ring[1] = 4'b0100; ring[2] = 4'b0010; ring[3] = 4'b0001;
        for (int i = 0; i < 12; i++) begin
            $display("clk %0d: q=%b pc=%03h", i, {q1, q2, q3, q4}, pc);
            checks++;
            if ({q1, q2, q3, q4} !== ring[i % 4]) begin errors++; $display("FAIL ring_q%0d: got %b want %b", i, {q1, q2, q3, q4}, ring[i % 4]); end
            checks++;
            if (pc !== 9'(RV + i / 4)) begin errors++; $display("FAIL ring_pc%0d: got %03h want %03h", i, pc, 9'(RV + i / 4)); end
            @(negedge clk);
        end
        m_pc = (m_pc + 3) & MASK;
    endtask

    task automatic test_wrap();
        run_instr(0, 0, 1, 9'h1FF, 8'h00, 0, 8'h00, 0);
        run_instr(0, 0, 0, 9'h000, 8'h00, 0, 8'h00, 0);
        checks++; if (pc !== 9'h000) begin errors++; $display("FAIL wrap_inc: got %03h want 000", pc); end
        run_instr(0, 0, 1, 9'h1FE, 8'h00, 0, 8'h00, 0);
        run_instr(0, 0, 0, 9'h000, 8'h00, 0, 8'h00, 1);
        checks++; if (pc !== 9'h000) begin errors++; $display("FAIL wrap_skip: got %03h want 000", pc); end
        run_instr(0, 0, 0, 9'h000, 8'h00, 1, 8'hA7, 0);
        checks++; if (pc !== 9'h0A7) begin errors++; $display("FAIL pcl_write: got %03h want 0A7", pc); end
    endtask

    task automatic test_call_ret();
        run_instr(0, 0, 1, 9'h010, 8'h00, 0, 8'h00, 0);
        run_instr(0, 1, 0, 9'h000, 8'h40, 0, 8'h00, 0);
        checks++; if (pc !== 9'h040) begin errors++; $display("FAIL call_pc: got %03h want 040", pc); end
        checks++; if (stack_level !== 2'd1) begin errors++; $display("FAIL call_level: got %0d want 1", stack_level); end
        run_instr(1, 0, 0, 9'h000, 8'h00, 0, 8'h00, 0);
        checks++; if (pc !== 9'h011) begin errors++; $display("FAIL ret_pc: got %03h want 011", pc); end
        checks++; if (stack_level !== 2'd0) begin errors++; $display("FAIL ret_level: got %0d want 0", stack_level); end
    endtask

    task automatic test_overflow();
        logic [8:0] exp_ret [3];
        exp_ret[0] = 9'h081; exp_ret[1] = 9'h041; exp_ret[2] = 9'h081;
        do_reset();
        run_instr(0, 0, 1, 9'h010, 8'h00, 0, 8'h00, 0);
        run_instr(0, 1, 0, 9'h000, 8'h40, 0, 8'h00, 0);
        run_instr(0, 1, 0, 9'h000, 8'h80, 0, 8'h00, 0);
        run_instr(0, 1, 0, 9'h000, 8'h10, 0, 8'h00, 0);
        checks++; if (stack_level !== 2'd2) begin errors++; $display("FAIL ovf_level: got %0d want 2", stack_level); end
        checks++; if (stack_ovf !== FLAGS_EN) begin errors++; $display("FAIL ovf_flag: got %b want %b", stack_ovf, FLAGS_EN); end
        checks++; if (stack_unf !== 1'b0) begin errors++; $display("FAIL ovf_unf_early: got %b want 0", stack_unf); end
        for (int i = 0; i < 3; i++) begin
            run_instr(1, 0, 0, 9'h000, 8'h00, 0, 8'h00, 0);
            checks++;
            if (pc !== exp_ret[i]) begin errors++; $display("FAIL ovf_ret%0d: got %03h want %03h", i, pc, exp_ret[i]); end
            checks++;
            if (stack_unf !== (FLAGS_EN && i == 2)) begin errors++; $display("FAIL unf_flag%0d: got %b want %b", i, stack_unf, FLAGS_EN && i == 2); end
        end
        checks++; if (stack_level !== 2'd0) begin errors++; $display("FAIL unf_level: got %0d want 0", stack_level); end
    endtask

    task automatic test_priority();
        int lvl_before;
        run_instr(0, 0, 1, 9'h030, 8'h00, 0, 8'h00, 0);
        lvl_before = m_level;
        run_instr(0, 1, 1, 9'h055, 8'h20, 1, 8'h99, 1);
        checks++; if (pc !== 9'h020) begin errors++; $display("FAIL prio_call: got %03h want 020", pc); end
        checks++; if (int'(stack_level) !== m_level || m_level != lvl_before + 1) begin errors++; $display("FAIL prio_level: got %0d want %0d", stack_level, m_level); end
        // Same strobes presented in Q2 only must be ignored.
        wait_phase(4'b0100);
        goto_enable = 1; goto_addr = 9'h055; call_enable = 1; call_addr = 8'h20;
        @(posedge clk);
        #1;
        clear_strobes();
        run_instr(0, 0, 0, 9'h000, 8'h00, 0, 8'h00, 0);
        checks++; if (pc !== 9'h021) begin errors++; $display("FAIL q2_ignored: got %03h want 021", pc); end
        checks++; if (int'(stack_level) !== m_level) begin errors++; $display("FAIL q2_level: got %0d want %0d", stack_level, m_level); end
    endtask

    task automatic test_random();
        bit r, c, g, w, s;
        logic [8:0] ga;
        logic [7:0] ca, pd;
        for (int n = 0; n < 200; n++) begin
            r = ($urandom_range(0, 99) < 20);
            c = ($urandom_range(0, 99) < 25);
            g = ($urandom_range(0, 99) < 25);
            w = ($urandom_range(0, 99) < 20);
            s = ($urandom_range(0, 99) < 25);
            ga = 9'($urandom); ca = 8'($urandom); pd = 8'($urandom);
            if (!m_known[(m_ptr + DEPTH - 1) % DEPTH]) r = 0;
            run_instr(r, c, g, ga, ca, w, pd, s);
            checks++;
            if (int'(pc) !== m_pc) begin errors++; $display("FAIL rand_pc%0d: got %03h want %03h", n, pc, m_pc); end
            checks++;
            if (int'(stack_level) !== m_level) begin errors++; $display("FAIL rand_level%0d: got %0d want %0d", n, stack_level, m_level); end
            checks++;
            if ({stack_ovf, stack_unf} !== {m_ovf & FLAGS_EN, m_unf & FLAGS_EN}) begin
                errors++;
                $display("FAIL rand_flags%0d: got %b want %b", n, {stack_ovf, stack_unf}, {m_ovf & FLAGS_EN, m_unf & FLAGS_EN});
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        run_instr(0, 1, 0, 9'h000, 8'h20, 0, 8'h00, 0);
        run_instr(0, 0, 1, 9'h033, 8'h00, 0, 8'h00, 0);
        checks++; if (pc !== 9'h033) begin errors++; $display("FAIL areset_setup: got %03h want 033", pc); end
        wait_phase(4'b0010);
        #2;
        rst = 1;
        #1;
        model_reset();
        $display("async reset mid-Q3: pc=%03h q=%b level=%0d", pc, {q1, q2, q3, q4}, stack_level);
        checks++; if (pc !== RV) begin errors++; $display("FAIL areset_pc: got %03h want %03h", pc, RV); end
        checks++; if ({q1, q2, q3, q4} !== 4'b1000) begin errors++; $display("FAIL areset_q: got %b want 1000", {q1, q2, q3, q4}); end
        checks++; if (stack_level !== 2'd0) begin errors++; $display("FAIL areset_level: got %0d want 0", stack_level); end
        checks++; if ({stack_ovf, stack_unf} !== 2'b00) begin errors++; $display("FAIL areset_flags: got %b want 00", {stack_ovf, stack_unf}); end
        @(negedge clk);
        rst = 0;
        run_instr(0, 0, 0, 9'h000, 8'h00, 0, 8'h00, 0);
        checks++; if (pc !== 9'(RV + 1)) begin errors++; $display("FAIL areset_resume: got %03h want %03h", pc, 9'(RV + 1)); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_phase_ring();
        test_wrap();
        test_call_ret();
        test_overflow();
        test_priority();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
